// File: rtl/frac_div_rem_pkg.sv
// Shared types and constants for the radix-2 restoring significand divider.
package frac_div_rem_pkg;

  localparam int FP16_FRACW = 10;

  typedef enum logic [1:0] {
    FDIV_IDLE,
    FDIV_DIV,
    FDIV_DONE
  } fdivState_t;

endpackage

// File: rtl/frac_div_fsm.sv
// Sequencer for the divider: accepts ops in IDLE/DONE, counts NUMW iterations.
module frac_div_fsm
  import frac_div_rem_pkg::*;
#(
  parameter int NUMW = 22
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic divisorZero,
  output logic loadEn,
  output logic iterEn,
  output logic resultEn,
  output logic zeroEn,
  output logic divDone
);

  localparam int CW = $clog2(NUMW);

  fdivState_t      state;
  logic [CW-1:0]   count;
  logic            accept;

  assign accept   = start && (state == FDIV_IDLE || state == FDIV_DONE);
  assign loadEn   = accept && !divisorZero;
  assign zeroEn   = accept && divisorZero;
  assign iterEn   = (state == FDIV_DIV);
  assign resultEn = iterEn && (count == CW'(NUMW - 1));
  assign divDone  = (state == FDIV_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FDIV_IDLE;
      count <= '0;
    end else begin
      unique case (state)
        FDIV_IDLE, FDIV_DONE: begin
          if (loadEn) begin
            state <= FDIV_DIV;
            count <= '0;
          end else if (zeroEn) begin
            state <= FDIV_DONE;
          end
        end
        FDIV_DIV: begin
          if (resultEn) state <= FDIV_DONE;
          else          count <= count + 1'b1;
        end
        default: state <= FDIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/frac_div_rem.sv
// Sequential unsigned divider: NUMW-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
module frac_div_rem
  import frac_div_rem_pkg::*;
#(
  parameter int WIDTH = FP16_FRACW + 1,
  parameter int NUMW  = 2 * WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [NUMW-1:0]  divIn,
  input  logic [WIDTH-1:0] divisorIn,
  output logic [NUMW-1:0]  quotOut,
  output logic [WIDTH-1:0] remOut,
  output logic             divZero,
  output logic             divDone
);

  logic loadEn, iterEn, resultEn, zeroEn;

  frac_div_fsm #(.NUMW(NUMW)) u_fsm (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .divisorZero (divisorIn == '0),
    .loadEn      (loadEn),
    .iterEn      (iterEn),
    .resultEn    (resultEn),
    .zeroEn      (zeroEn),
    .divDone     (divDone)
  );

  // Partial remainder stays below the divisor, so only the shifted value needs WIDTH+1 bits.
  logic [WIDTH-1:0] rem_q;
  logic [NUMW-1:0]  quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [NUMW-1:0]  quo_next;

  assign shifted  = {rem_q, quo_q[NUMW-1]};
  assign fits     = shifted >= {1'b0, dsr_q};
  assign rem_next = fits ? (shifted[WIDTH-1:0] - dsr_q) : shifted[WIDTH-1:0];
  assign quo_next = {quo_q[NUMW-2:0], fits};

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      quotOut <= '0;
      remOut  <= '0;
      divZero <= 1'b0;
    end else begin
      if (loadEn) begin
        rem_q <= '0;
        quo_q <= divIn;
        dsr_q <= divisorIn;
      end else if (iterEn) begin
        rem_q <= rem_next;
        quo_q <= quo_next;
      end

      // Results only change on completion, so a new op never exposes partial values.
      if (resultEn) begin
        quotOut <= quo_next;
        remOut  <= rem_next;
        divZero <= 1'b0;
      end else if (zeroEn) begin
        quotOut <= '1;
        remOut  <= divIn[WIDTH-1:0];
        divZero <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frac_div_rem.sv
// Directed + random self-checking bench for frac_div_rem (WIDTH=11, NUMW=22).
module tb_frac_div_rem;

  localparam int WIDTH = 11;
  localparam int NUMW  = 22;

  typedef struct {
    logic [NUMW-1:0]  n;
    logic [WIDTH-1:0] d;
    logic [NUMW-1:0]  q;
    logic [WIDTH-1:0] r;
    logic             z;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [NUMW-1:0]  divIn;
  logic [WIDTH-1:0] divisorIn;
  logic [NUMW-1:0]  quotOut;
  logic [WIDTH-1:0] remOut;
  logic             divZero;
  logic             divDone;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  frac_div_rem #(.WIDTH(WIDTH), .NUMW(NUMW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .divIn     (divIn),
    .divisorIn (divisorIn),
    .quotOut   (quotOut),
    .remOut    (remOut),
    .divZero   (divZero),
    .divDone   (divDone)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one accepting edge and record the expected result.
  task automatic launch(input logic [NUMW-1:0] n, input logic [WIDTH-1:0] d);
    exp_t e;
    e.n = n;
    e.d = d;
    if (d == '0) begin
      e.q = '1;
      e.r = n[WIDTH-1:0];
      e.z = 1'b1;
    end else begin
      e.q = n / NUMW'(d);
      e.r = WIDTH'(n % NUMW'(d));
      e.z = 1'b0;
    end
    sb.push_back(e);
    start     = 1'b1;
    divIn     = n;
    divisorIn = d;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_op(input string tag, input int exp_wait);
    int   waited;
    exp_t e;
    waited = 0;
    while (!divDone && waited < 64) begin
      tick();
      waited++;
    end
    check({tag, "_latency"}, 64'(waited), 64'(exp_wait));
    e = sb.pop_front();
    check({tag, "_done"}, 64'(divDone), 64'd1);
    check({tag, "_quot"}, 64'(quotOut), 64'(e.q));
    check({tag, "_rem"},  64'(remOut),  64'(e.r));
    check({tag, "_zero"}, 64'(divZero), 64'(e.z));
    if (e.d != '0) begin
      check({tag, "_inv_qdr"}, 64'(quotOut) * 64'(e.d) + 64'(remOut), 64'(e.n));
      check({tag, "_inv_rltd"}, 64'(remOut < e.d), 64'd1);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_done"}, 64'(divDone), 64'd0);
    check({tag, "_quot"}, 64'(quotOut), 64'd0);
    check({tag, "_rem"},  64'(remOut),  64'd0);
    check({tag, "_zero"}, 64'(divZero), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    divIn     = '0;
    divisorIn = '0;
    tick();
    tick();
    check_cleared("reset");
    reset = 1'b0;
    tick();
    check("idle_no_start", 64'(divDone), 64'd0);

    // Basic ops and boundary operands.
    launch(22'd1000, 11'd7);
    check("t1_busy", 64'(divDone), 64'd0);
    finish_op("t1", NUMW);
    launch(22'h3FFFFF, 11'h7FF);
    finish_op("t2_max", NUMW);
    launch(22'd5, 11'd9);
    finish_op("t2_small", NUMW);

    // Zero divisor completes on the accepting edge.
    launch(22'h00ABC, 11'd0);
    finish_op("t3_dz", 0);
    check("t3_quot_ones", 64'(quotOut), 64'h3FFFFF);
    check("t3_rem_low", 64'(remOut), 64'h2BC);

    // Reset on the 10th DIV edge clears outputs; a fresh op then completes.
    launch(22'd1000, 11'd7);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    check_cleared("t4_abort");
    void'(sb.pop_front());
    reset = 1'b0;
    launch(22'd1000, 11'd7);
    finish_op("t4_after", NUMW);

    // Operand and start noise while dividing must be ignored.
    launch(22'd1000, 11'd7);
    for (int i = 0; i < NUMW - 1; i++) begin
      start     = (i % 2 == 0);
      divIn     = NUMW'($urandom);
      divisorIn = WIDTH'($urandom);
      tick();
    end
    start = 1'b0;
    tick();
    finish_op("t5", 0);

    // Back-to-back accept from DONE: old result held until the new one lands.
    start     = 1'b1;
    divIn     = 22'd300;
    divisorIn = 11'd11;
    sb.push_back('{n: 22'd300, d: 11'd11, q: 22'd27, r: 11'd3, z: 1'b0});
    tick();
    for (int i = 0; i < NUMW; i++) begin
      check("t6_low", 64'(divDone), 64'd0);
      check("t6_hold_q", 64'(quotOut), 64'd142);
      check("t6_hold_r", 64'(remOut), 64'd6);
      tick();
    end
    start = 1'b0;
    finish_op("t6", 0);

    // Random operands with occasional mid-op reset.
    for (int k = 0; k < 200; k++) begin
      logic [NUMW-1:0]  n;
      logic [WIDTH-1:0] d;
      n = NUMW'($urandom);
      d = ($urandom_range(0, 15) == 0) ? '0 : WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        launch(n, d);
        repeat ($urandom_range(0, NUMW - 1)) tick();
        reset = 1'b1;
        tick();
        check_cleared("rnd_abort");
        void'(sb.pop_front());
        reset = 1'b0;
      end else begin
        launch(n, d);
        finish_op("rnd", (d == '0) ? 0 : NUMW);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
